tx_arbiter: RTL and testbench

- Shares the single 8N1 UART transmitter between N byte-stream requesters.
- Each requester presents packets as valid/ready bytes, with `req_last` marking the final byte.
- Grants are issued round-robin and held for a whole packet, so packets never interleave on the wire.
- Optionally prepends a one-byte source header; sits between the host-side producers (debug, telemetry, command responses) and the UART transmitter.

---
 rtl/tx_arbiter.sv | 168 ++++++++++++++++
 tb/tb_tx_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_arbiter.sv
// Round-robin arbiter that shares one 8N1 UART transmitter between N packet
// requesters, holding each grant for a whole packet and optionally prefixing a source header.
module tx_arbiter #(
  parameter int unsigned N      = 4,
  parameter bit          HEADER = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  input  logic [8*N-1:0]   req_data,
  input  logic [N-1:0]     req_last,
  output logic [N-1:0]     req_ready,
  output logic             tx_stb,
  output logic [7:0]       tx_dat,
  input  logic             tx_rdy,
  output logic [N-1:0]     grant,
  output logic             busy
);

  localparam int unsigned IDW = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_LOAD  = 3'd2,
    S_ISSUE = 3'd3,
    S_ACK   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [N-1:0]   req_ready_q, req_ready_d;
  logic           busy_q, busy_d;
  logic           tx_stb_q, tx_stb_d;
  logic [7:0]     tx_dat_q, tx_dat_d;
  logic           last_q, last_d;
  logic           ret_done_q, ret_done_d;

  logic           own_valid;
  logic           own_last;
  logic [7:0]     own_data;
  logic           hit;
  logic [IDW-1:0] win;

  // Current owner's request lane
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = 8'h00;
    for (int unsigned i = 0; i < N; i++) begin
      if (id_q == IDW'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[8*i +: 8];
      end
    end
  end

  // First valid requester at or after the pointer, wrapping modulo N
  always_comb begin
    hit = 1'b0;
    win = '0;
    for (int unsigned k = 0; k < N; k++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!hit && req_valid[i] && (((32'(ptr_q) + k) % N) == i)) begin
          hit = 1'b1;
          win = IDW'(i);
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    req_ready_d = '0;
    tx_stb_d    = 1'b0;
    tx_dat_d    = tx_dat_q;
    last_d      = last_q;
    ret_done_d  = ret_done_q;

    unique case (state_q)
      S_IDLE: begin
        if (hit) begin
          id_d    = win;
          grant_d = N'(1) << win;
          busy_d  = 1'b1;
          state_d = HEADER ? S_HDR : S_LOAD;
        end
      end
      S_HDR: begin
        if (tx_rdy) begin
          tx_dat_d   = {4'hA, 1'b0, id_q};
          tx_stb_d   = 1'b1;
          ret_done_d = 1'b0;
          state_d    = S_ACK;
        end
      end
      S_LOAD: begin
        if (own_valid) begin
          req_ready_d = grant_q;
          tx_dat_d    = own_data;
          last_d      = own_last;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (tx_rdy) begin
          tx_stb_d   = 1'b1;
          ret_done_d = last_q;
          state_d    = S_ACK;
        end
      end
      // tx_rdy is still high on the acceptance edge, so this cycle only lets it fall
      S_ACK: begin
        state_d = ret_done_q ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        ptr_d   = (id_q == IDW'(N-1)) ? '0 : id_q + 1'b1;
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      id_q        <= '0;
      ptr_q       <= '0;
      grant_q     <= '0;
      req_ready_q <= '0;
      busy_q      <= 1'b0;
      tx_stb_q    <= 1'b0;
      tx_dat_q    <= 8'h00;
      last_q      <= 1'b0;
      ret_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      tx_stb_q    <= tx_stb_d;
      tx_dat_q    <= tx_dat_d;
      last_q      <= last_d;
      ret_done_q  <= ret_done_d;
    end
  end

  assign req_ready = req_ready_q;
  assign tx_stb    = tx_stb_q;
  assign tx_dat    = tx_dat_q;
  assign grant     = grant_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: one instance without and one with source headers, each driven by
// queued requesters and a UART model, checked by a scoreboard against a round-robin packet model.
module tb_tx_arbiter;

  localparam int unsigned N = 4;

  typedef struct {
    logic [7:0] d;
    logic       last;
    int         gap;
  } rbyte_t;

  typedef struct {
    logic [7:0] d;
    int         src;
  } exp_t;

  logic clk;
  int   errors = 0;
  int   checks = 0;
  bit   done [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int inst, input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL h%0d %s: got 0x%0h, expected 0x%0h", inst, name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam bit HDR = (g == 1);

    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_stb;
    logic [7:0]     tx_dat;
    logic           tx_rdy;
    logic [N-1:0]   grant;
    logic           busy;

    tx_arbiter #(.N(N), .HEADER(HDR)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .tx_stb    (tx_stb),
      .tx_dat    (tx_dat),
      .tx_rdy    (tx_rdy),
      .grant     (grant),
      .busy      (busy)
    );

    rbyte_t     rq      [N][$];
    logic [7:0] md      [N][$];
    int         plen    [N][$];
    int         cur_len [N];
    int         gap_cnt [N];
    int         popped  [N];
    bit         gate    [N];
    exp_t       exp_q   [$];
    int         mptr;
    int         uart_cnt;
    logic       prev_stb;
    logic [N-1:0] prev_grant;

    // Monitor, UART model and requester drivers, all stepped at the falling edge
    initial begin
      tx_rdy = 1'b1; req_valid = '0; req_data = '0; req_last = '0;
      uart_cnt = 0; prev_stb = 1'b0; prev_grant = '0;
      for (int r = 0; r < N; r++) gap_cnt[r] = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          tx_rdy = 1'b1; uart_cnt = 0; prev_stb = 1'b0; prev_grant = '0;
          for (int r = 0; r < N; r++) gap_cnt[r] = 0;
        end else begin
          chk(g, busy == (grant != '0), "busy vs grant", 32'(busy), 32'(grant != '0));
          chk(g, $onehot0(grant), "grant one-hot", 32'(grant), 32'(0));
          if (prev_grant != '0 && grant != '0)
            chk(g, grant == prev_grant, "grant held in packet", 32'(grant), 32'(prev_grant));
          if (req_ready != '0) begin
            chk(g, req_ready == grant, "req_ready owner", 32'(req_ready), 32'(grant));
            chk(g, (req_ready & ~req_valid) == '0, "req_ready needs valid",
                32'(req_ready), 32'(req_valid));
          end
          if (tx_stb) begin
            chk(g, tx_rdy == 1'b1, "strobe while uart busy", 32'(tx_rdy), 32'(1));
            chk(g, !prev_stb, "back-to-back strobe", 32'(prev_stb), 32'(0));
            if (exp_q.size() == 0) begin
              chk(g, 1'b0, "unexpected strobe", 32'(tx_dat), 32'(0));
            end else begin
              exp_t e;
              logic [N-1:0] oh;
              e = exp_q.pop_front();
              oh = '0;
              oh[e.src] = 1'b1;
              chk(g, tx_dat == e.d, "tx_dat", 32'(tx_dat), 32'(e.d));
              chk(g, grant == oh, "grant at strobe", 32'(grant), 32'(oh));
            end
          end
          prev_stb = tx_stb;
          prev_grant = grant;
          if (tx_stb && tx_rdy) begin
            tx_rdy = 1'b0;
            uart_cnt = int'($urandom_range(4, 14));
          end else if (!tx_rdy) begin
            if (uart_cnt > 0) uart_cnt--;
            if (uart_cnt == 0) tx_rdy = 1'b1;
          end
          for (int r = 0; r < N; r++) begin
            if (req_ready[r] && rq[r].size() > 0) begin
              void'(rq[r].pop_front());
              popped[r]++;
              gap_cnt[r] = (rq[r].size() > 0) ? rq[r][0].gap : 0;
            end else if (gap_cnt[r] > 0) begin
              gap_cnt[r]--;
            end
          end
        end
        for (int r = 0; r < N; r++) begin
          req_valid[r] = gate[r] && (rq[r].size() > 0) && (gap_cnt[r] == 0);
          if (rq[r].size() > 0) begin
            req_data[8*r +: 8] = rq[r][0].d;
            req_last[r] = rq[r][0].last;
          end
        end
      end
    end

    task automatic add_byte(input int r, input logic [7:0] d, input bit last, input int gap);
      rbyte_t b;
      b.d = d; b.last = last; b.gap = gap;
      rq[r].push_back(b);
      md[r].push_back(d);
      cur_len[r]++;
      if (last) begin
        plen[r].push_back(cur_len[r]);
        cur_len[r] = 0;
      end
    endtask

    // stall < 0 picks a small random gap before each non-first byte
    task automatic add_pkt(input int r, input int len, input int stall);
      for (int i = 0; i < len; i++)
        add_byte(r, 8'($urandom), i == len - 1,
                 (i == 0) ? 0 : ((stall >= 0) ? stall : int'($urandom_range(0, 3))));
    endtask

    // Serve whole packets round-robin from the pointer; append the expected byte stream
    task automatic plan();
      bool_loop: forever begin
        int r;
        bit found;
        found = 1'b0; r = 0;
        for (int k = 0; k < N; k++) begin
          int c;
          c = (mptr + k) % N;
          if (!found && plen[c].size() > 0) begin found = 1'b1; r = c; end
        end
        if (!found) disable bool_loop;
        begin
          int len;
          exp_t e;
          len = plen[r].pop_front();
          e.src = r;
          if (HDR) begin
            e.d = 8'hA0 | 8'(r);
            exp_q.push_back(e);
          end
          for (int i = 0; i < len; i++) begin
            e.d = md[r].pop_front();
            exp_q.push_back(e);
          end
          mptr = (r + 1) % N;
        end
      end
    endtask

    task automatic wait_drain(input string name);
      bit empty;
      int i;
      empty = 1'b0; i = 0;
      while (!empty && i < 4000) begin
        @(posedge clk); #2;
        empty = (exp_q.size() == 0) && tx_rdy;
        for (int r = 0; r < N; r++) if (rq[r].size() != 0) empty = 1'b0;
        i++;
      end
      chk(g, empty, {name, " drain"}, 32'(exp_q.size()), 32'(0));
      repeat (3) @(posedge clk);
      #2;
      chk(g, grant == '0 && !busy, {name, " idle after packet"}, 32'({busy, grant}), 32'(0));
    endtask

    task automatic wait_popped(input int r, input int n, input string name);
      int i;
      i = 0;
      while (popped[r] < n && i < 2000) begin
        @(posedge clk); #2;
        i++;
      end
      chk(g, popped[r] >= n, {name, " bytes consumed"}, 32'(popped[r]), 32'(n));
    endtask

    task automatic clear_model();
      for (int r = 0; r < N; r++) begin
        rq[r].delete(); md[r].delete(); plen[r].delete();
        cur_len[r] = 0; popped[r] = 0; gate[r] = 1'b1;
      end
      exp_q.delete();
      mptr = 0;
    endtask

    // Scenario sequence
    initial begin
      int n;
      int stb_cnt;
      rst = 1'b1;
      clear_model();
      repeat (3) @(posedge clk);
      #1;
      chk(g, req_ready == '0, "reset req_ready", 32'(req_ready), 32'(0));
      chk(g, tx_stb == 1'b0, "reset tx_stb", 32'(tx_stb), 32'(0));
      chk(g, tx_dat == 8'h00, "reset tx_dat", 32'(tx_dat), 32'(0));
      chk(g, grant == '0, "reset grant", 32'(grant), 32'(0));
      chk(g, busy == 1'b0, "reset busy", 32'(busy), 32'(0));
      #1 rst = 1'b0;

      // Single requester, two bytes
      @(posedge clk); #2;
      add_byte(0, 8'h55, 1'b0, 0);
      add_byte(0, 8'hAA, 1'b1, 0);
      plan();
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!tx_stb && n < 50);
      chk(g, tx_stb && (n - 1) >= 2, "first strobe latency", 32'(n - 1), 32'(2));
      wait_drain("single");

      // One-byte packet from requester 2
      @(posedge clk); #2;
      add_byte(2, 8'h10, 1'b1, 0);
      plan();
      wait_drain("one-byte");

      // Requester 1 joins mid-way through requester 0's packet
      @(posedge clk); #2;
      gate[1] = 1'b0;
      add_pkt(0, 3, 0);
      add_pkt(1, 2, 0);
      plan();
      wait_popped(0, 1, "interleave");
      gate[1] = 1'b1;
      wait_drain("interleave");

      // Owner stalls for 50 cycles between bytes
      @(posedge clk); #2;
      for (int r = 0; r < N; r++) popped[r] = 0;
      add_pkt(1, 2, 50);
      plan();
      wait_popped(1, 1, "stall");
      repeat (10) @(posedge clk);
      stb_cnt = 0;
      repeat (30) begin
        @(negedge clk);
        if (tx_stb) stb_cnt++;
      end
      chk(g, stb_cnt == 0, "strobes during stall", 32'(stb_cnt), 32'(0));
      chk(g, grant == 4'b0010, "grant during stall", 32'(grant), 32'(4'b0010));
      wait_drain("stall");

      // Fairness from pointer 0, requester 0 re-requests
      @(posedge clk); #2 rst = 1'b1;
      clear_model();
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      for (int r = 0; r < N; r++) add_pkt(r, 2, -1);
      add_pkt(0, 2, -1);
      plan();
      wait_drain("fairness");

      // Randomized packet mixes
      for (int s = 0; s < 16; s++) begin
        bit any;
        @(posedge clk); #2;
        any = 1'b0;
        for (int r = 0; r < N; r++) begin
          int np;
          np = int'($urandom_range(0, 2));
          for (int p = 0; p < np; p++) begin
            add_pkt(r, int'($urandom_range(1, 4)), -1);
            any = 1'b1;
          end
        end
        if (!any) add_pkt(int'($urandom_range(0, N - 1)), 1, 0);
        plan();
        wait_drain("random");
      end

      // Reset after the second of four bytes, then a fresh packet from requester 3
      @(posedge clk); #2;
      for (int r = 0; r < N; r++) popped[r] = 0;
      add_pkt(0, 4, 0);
      plan();
      wait_popped(0, 2, "reset mid-packet");
      @(posedge clk); #2 rst = 1'b1;
      clear_model();
      @(posedge clk); #1;
      chk(g, req_ready == '0, "mid reset req_ready", 32'(req_ready), 32'(0));
      chk(g, tx_stb == 1'b0, "mid reset tx_stb", 32'(tx_stb), 32'(0));
      chk(g, grant == '0, "mid reset grant", 32'(grant), 32'(0));
      chk(g, busy == 1'b0, "mid reset busy", 32'(busy), 32'(0));
      @(posedge clk); #2 rst = 1'b0;
      add_pkt(3, 2, 0);
      plan();
      wait_drain("after reset");

      done[g] = 1'b1;
    end
  end

  initial begin
    bit all_done;
    all_done = 1'b0;
    for (int i = 0; i < 60000 && !all_done; i++) begin
      @(posedge clk);
      all_done = done[0] && done[1];
    end
    checks++;
    if (!all_done) begin
      errors++;
      $display("FAIL run timeout: done=%0d%0d, expected 11", done[1], done[0]);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
